// File: rtl/parity_stream_unit_pkg.sv
// Shared constants for the parity stream unit: frame FSM states and parity mode encoding.
package parity_stream_unit_pkg;

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] IN_FRAME = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_stream_unit_parity.sv
// Combinational parity of one word; odd mode inverts the XOR-reduce.
module parity_calc
  import parity_stream_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic              mode,
  output logic              par_c
);

  assign par_c = (^data) ^ (mode == PAR_ODD);

endmodule

// File: rtl/parity_stream_unit.sv
// Streaming parity generator/checker with frame parity, one-entry output register and error counter.
module parity_stream_unit
  import parity_stream_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_par,
  input  logic              s_last,
  input  logic              mode_odd,
  input  logic              chk_en,
  input  logic              err_clr,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_par,
  output logic              m_last,
  output logic              m_frame_par,
  output logic              m_err,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic              mode_q;
  logic              chk_q;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_fold;
  logic              accept;
  logic              first_beat;
  logic              beat_mode;
  logic              beat_chk;
  logic              word_par;
  logic              frame_par;
  logic              beat_err;

  assign s_ready    = !m_valid || m_ready;
  assign accept     = s_valid && s_ready;
  assign first_beat = (state == IDLE);

  // Frame settings come live from the ports on the first beat, latched afterwards.
  assign beat_mode = first_beat ? mode_odd : mode_q;
  assign beat_chk  = first_beat ? chk_en   : chk_q;
  assign acc_fold  = acc ^ s_data;

  parity_calc #(.DATA_W(DATA_W)) u_word_par (
    .data  (s_data),
    .mode  (beat_mode),
    .par_c (word_par)
  );

  parity_calc #(.DATA_W(DATA_W)) u_frame_par (
    .data  (acc_fold),
    .mode  (beat_mode),
    .par_c (frame_par)
  );

  assign beat_err = beat_chk && (s_par != word_par);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && !s_last) begin
          state_nxt = IN_FRAME;
        end
      end
      IN_FRAME: begin
        if (accept && s_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame context: settings latch and running XOR fold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= PAR_EVEN;
      chk_q  <= 1'b0;
      acc    <= '0;
    end else if (accept) begin
      if (first_beat) begin
        mode_q <= mode_odd;
        chk_q  <= chk_en;
      end
      acc <= s_last ? '0 : acc_fold;
    end
  end

  // Output register holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_par       <= 1'b0;
      m_last      <= 1'b0;
      m_frame_par <= 1'b0;
      m_err       <= 1'b0;
    end else if (accept) begin
      m_valid     <= 1'b1;
      m_data      <= s_data;
      m_par       <= word_par;
      m_last      <= s_last;
      m_frame_par <= frame_par;
      m_err       <= beat_err;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= (accept && beat_err) ? CNT_W'(1) : '0;
    end else if (accept && beat_err && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_parity_stream_unit.sv
// Randomized and directed bench for parity_stream_unit against a frame-level reference model.
module tb_parity_stream_unit;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_W   = 2;
  localparam int          CNT_SAT = 3;

  logic              clk;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_par;
  logic              s_last;
  logic              mode_odd;
  logic              chk_en;
  logic              err_clr;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_par;
  logic              m_last;
  logic              m_frame_par;
  logic              m_err;
  logic [CNT_W-1:0]  err_cnt;

  parity_stream_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_par       (s_par),
    .s_last      (s_last),
    .mode_odd    (mode_odd),
    .chk_en      (chk_en),
    .err_clr     (err_clr),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_par       (m_par),
    .m_last      (m_last),
    .m_frame_par (m_frame_par),
    .m_err       (m_err),
    .err_cnt     (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: expected outputs plus the open frame's settings and bit count.
  logic              exp_valid;
  logic [DATA_W-1:0] exp_data;
  logic              exp_par;
  logic              exp_last;
  logic              exp_fpar;
  logic              exp_err;
  int                exp_cnt;
  logic              frame_open;
  logic              fr_odd;
  logic              fr_chk;
  int                frame_ones;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  task automatic model_reset();
    exp_valid  = 1'b0;
    exp_data   = '0;
    exp_par    = 1'b0;
    exp_last   = 1'b0;
    exp_fpar   = 1'b0;
    exp_err    = 1'b0;
    exp_cnt    = 0;
    frame_open = 1'b0;
    fr_odd     = 1'b0;
    fr_chk     = 1'b0;
    frame_ones = 0;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic p, input logic l,
                       input logic odd, input logic chk, input logic clr, input logic mr);
    s_valid  = v;
    s_data   = d;
    s_par    = p;
    s_last   = l;
    mode_odd = odd;
    chk_en   = chk;
    err_clr  = clr;
    m_ready  = mr;
  endtask

  task automatic check_outputs();
    check("m_valid", 32'(m_valid), 32'(exp_valid));
    check("m_data", 32'(m_data), 32'(exp_data));
    check("m_par", 32'(m_par), 32'(exp_par));
    check("m_last", 32'(m_last), 32'(exp_last));
    check("m_frame_par", 32'(m_frame_par), 32'(exp_fpar));
    check("m_err", 32'(m_err), 32'(exp_err));
    check("err_cnt", 32'(err_cnt), 32'(exp_cnt));
  endtask

  // Called at the falling edge with inputs already driven; advances one clock.
  task automatic cycle();
    logic exp_rdy;
    logic take;
    logic wpar;
    logic berr;
    int   ones;
    #1;
    exp_rdy = !exp_valid || m_ready;
    check("s_ready", 32'(s_ready), 32'(exp_rdy));
    take = s_valid && exp_rdy;
    berr = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (take) begin
        if (!frame_open) begin
          fr_odd     = mode_odd;
          fr_chk     = chk_en;
          frame_ones = 0;
        end
        ones       = $countones(s_data);
        frame_ones = frame_ones + ones;
        wpar       = ((ones % 2) == 1) ^ fr_odd;
        berr       = fr_chk && (s_par != wpar);
        exp_valid  = 1'b1;
        exp_data   = s_data;
        exp_par    = wpar;
        exp_last   = s_last;
        exp_fpar   = ((frame_ones % 2) == 1) ^ fr_odd;
        exp_err    = berr;
        frame_open = !s_last;
      end else if (m_ready) begin
        exp_valid = 1'b0;
      end
      if (err_clr) exp_cnt = (take && berr) ? 1 : 0;
      else if (take && berr && exp_cnt < CNT_SAT) exp_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Odd mode, single zero word
    drive(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle();
    check("r36_par", 32'(m_par), 32'd1);
    check("r36_fpar", 32'(m_frame_par), 32'd1);
    check("r36_last", 32'(m_last), 32'd1);

    // Even mode single beats
    drive(1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    check("r37_par_07", 32'(m_par), 32'd1);
    drive(1'b1, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    check("r37_par_0f", 32'(m_par), 32'd0);

    // Two-beat odd frame with mode flipped mid-frame
    drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle();
    check("r38_par0", 32'(m_par), 32'd0);
    drive(1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    check("r38_par1", 32'(m_par), 32'd1);
    check("r38_fpar", 32'(m_frame_par), 32'd0);

    // Error counting, saturation and clear interaction
    drive(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle();
    check("r39_err", 32'(m_err), 32'd1);
    check("r39_cnt1", 32'(err_cnt), 32'd1);
    repeat (3) cycle();
    check("r39_sat", 32'(err_cnt), 32'd3);
    drive(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    cycle();
    check("r39_clr_err", 32'(err_cnt), 32'd1);
    drive(1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    cycle();
    check("r39_clr", 32'(err_cnt), 32'd0);

    // Backpressure hold
    drive(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    drive(1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      cycle();
      check("r40_hold_data", 32'(m_data), 32'hA5);
      check("r40_hold_rdy", 32'(s_ready), 32'd0);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    check("r40_drain_valid", 32'(m_valid), 32'd0);
    check("r40_drain_rdy", 32'(s_ready), 32'd1);

    // Reset mid-frame discards the partial frame
    drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle();
    drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle();
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    check("r41_rst_valid", 32'(m_valid), 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle();
    check("r41_fpar", 32'(m_frame_par), 32'd0);
    check("r41_valid", 32'(m_valid), 32'd1);

    // Random traffic with stalls, clears and occasional resets
    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      drive(($urandom_range(0, 9) < 7), DATA_W'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
            1'($urandom), 1'($urandom), ($urandom_range(0, 11) == 0), ($urandom_range(0, 9) < 7));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
